// File: rtl/elevator_scheduler.sv
// SCAN (sweep) scheduler for one elevator car: latches floor calls, picks the next stop, holds the door.
// Optional build macro ELEV_SCHED_RECALL_EN adds a recall input that sends the car to floor 0.
module elevator_scheduler #(
    parameter int NUM_FLOORS   = 8,
    parameter int DWELL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
`ifdef ELEV_SCHED_RECALL_EN
    input  logic       recall,
`endif
    input  logic       call_valid,
    input  logic [2:0] call_floor,
    input  logic [2:0] current_floor,
    input  logic       moving,
    output logic [2:0] req_floor,
    output logic [7:0] pending,
    output logic       dir_up,
    output logic       door_open,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_UP   = 2'd1,
        SERVE_DOWN = 2'd2,
        DWELL      = 2'd3
    } state_t;

    localparam logic [7:0] FLOOR_MASK = 8'((16'd1 << NUM_FLOORS) - 16'd1);

    state_t     state;
    logic [3:0] dwell_cnt;

    logic       call_ok;
    logic [7:0] call_bit;
    logic [7:0] pend_eff;
    logic       arrive;
    logic [7:0] clear_bit;
    logic [7:0] pending_nxt;
    logic [7:0] ge_mask;
    logic       up_found;
    logic [2:0] up_floor;
    logic       dn_found;
    logic [2:0] dn_floor;

    // Valid valid/ready-free strobe interface: a call is taken whenever call_valid is high at an edge.
    always_comb begin
        call_ok     = call_valid && ({1'b0, call_floor} < 4'(NUM_FLOORS))
                      && !(state == DWELL && call_floor == current_floor);
        call_bit    = call_ok ? (8'd1 << call_floor) : 8'd0;
        // Targets see this cycle's call so a closer floor retargets immediately.
        pend_eff    = (pending | call_bit) & FLOOR_MASK;
        arrive      = (state == SERVE_UP || state == SERVE_DOWN) && !moving
                      && current_floor == req_floor && pending[req_floor];
        clear_bit   = arrive ? (8'd1 << req_floor) : 8'd0;
        // Clearing after the OR lets an arrival-floor call be absorbed by the stop.
        pending_nxt = pend_eff & ~clear_bit;
        ge_mask     = ~((8'd1 << current_floor) - 8'd1);

        up_found = 1'b0;
        up_floor = 3'd0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pend_eff[3'(i)] && 3'(i) >= current_floor) begin
                up_found = 1'b1;
                up_floor = 3'(i);
            end
        end

        dn_found = 1'b0;
        dn_floor = 3'd0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend_eff[3'(i)] && 3'(i) <= current_floor) begin
                dn_found = 1'b1;
                dn_floor = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 8'd0;
            dir_up    <= 1'b1;
            door_open <= 1'b0;
            req_floor <= 3'd0;
            dwell_cnt <= 4'd0;
        end
`ifdef ELEV_SCHED_RECALL_EN
        else if (recall) begin
            pending   <= 8'd0;
            req_floor <= 3'd0;
            dir_up    <= 1'b0;
            door_open <= 1'b0;
            dwell_cnt <= 4'd0;
            state     <= (current_floor == 3'd0 && !moving) ? IDLE : SERVE_DOWN;
        end
`endif
        else begin
            pending <= pending_nxt;
            case (state)
                IDLE: begin
                    req_floor <= current_floor;
                    if (pending != 8'd0) begin
                        if ((pending & ge_mask) != 8'd0) begin
                            state  <= SERVE_UP;
                            dir_up <= 1'b1;
                        end else begin
                            state  <= SERVE_DOWN;
                            dir_up <= 1'b0;
                        end
                    end
                end
                SERVE_UP: begin
                    if (arrive) begin
                        state     <= DWELL;
                        door_open <= 1'b1;
                        dwell_cnt <= 4'd0;
                    end else if (pend_eff == 8'd0) begin
                        state <= IDLE;
                    end else if (up_found) begin
                        req_floor <= up_floor;
                    end else begin
                        state  <= SERVE_DOWN;
                        dir_up <= 1'b0;
                    end
                end
                SERVE_DOWN: begin
                    if (arrive) begin
                        state     <= DWELL;
                        door_open <= 1'b1;
                        dwell_cnt <= 4'd0;
                    end else if (pend_eff == 8'd0) begin
                        state <= IDLE;
                    end else if (dn_found) begin
                        req_floor <= dn_floor;
                    end else begin
                        state  <= SERVE_UP;
                        dir_up <= 1'b1;
                    end
                end
                DWELL: begin
                    // req_floor is deliberately untouched so the car stays put.
                    if (dwell_cnt == 4'(DWELL_CYCLES - 1)) begin
                        door_open <= 1'b0;
                        dwell_cnt <= 4'd0;
                        if (pending_nxt != 8'd0)
                            state <= dir_up ? SERVE_UP : SERVE_DOWN;
                        else
                            state <= IDLE;
                    end else begin
                        dwell_cnt <= dwell_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: a simple car model drives current_floor/moving, a call-ledger model
// tracks outstanding calls and checks every stop, every dwell length and the pending bitmap.
module tb_elevator_scheduler;

    localparam int NUM_FLOORS   = 8;
    localparam int DWELL_CYCLES = 4;
    localparam int TRAVEL       = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       call_valid;
    logic [2:0] call_floor;
    logic [2:0] current_floor;
    logic       moving;
    logic [2:0] req_floor;
    logic [7:0] pending;
    logic       dir_up;
    logic       door_open;
    logic       busy;
`ifdef ELEV_SCHED_RECALL_EN
    logic       recall = 1'b0;
`endif

    int compared   = 0;
    int mismatched = 0;
    int tcnt       = 0;

    // Ledger of outstanding calls: set when a call is accepted, cleared when a door opens there.
    logic [7:0] want = 8'd0;
    logic       st_valid = 1'b0;
    logic [2:0] st_floor = 3'd0;
    logic       st_door  = 1'b0;
    logic [2:0] st_cf    = 3'd0;
    logic       prev_door = 1'b0;
    int         dlen = 0;

    always #5 clk = ~clk;

    elevator_scheduler #(
        .NUM_FLOORS  (NUM_FLOORS),
        .DWELL_CYCLES(DWELL_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef ELEV_SCHED_RECALL_EN
        .recall       (recall),
`endif
        .call_valid   (call_valid),
        .call_floor   (call_floor),
        .current_floor(current_floor),
        .moving       (moving),
        .req_floor    (req_floor),
        .pending      (pending),
        .dir_up       (dir_up),
        .door_open    (door_open),
        .busy         (busy)
    );

    always @(negedge clk) begin
        if (reset) begin
            want = 8'd0; st_valid = 1'b0; prev_door = 1'b0; dlen = 0;
        end
`ifdef ELEV_SCHED_RECALL_EN
        else if (recall) begin
            want = 8'd0; st_valid = 1'b0; prev_door = door_open; dlen = 0;
        end
`endif
        else begin
            // The call staged at the previous negedge was sampled by the edge in between.
            if (st_valid && int'(st_floor) < NUM_FLOORS && !(st_door && st_floor == st_cf))
                want[st_floor] = 1'b1;
            if (door_open && !prev_door) begin
                compared++;
                if (want[current_floor] !== 1'b1 || moving !== 1'b0) begin
                    mismatched++;
                    $display("FAIL stop_valid: door opened at floor %0d (moving=%0b), outstanding calls %b",
                             current_floor, moving, want);
                end
                want[current_floor] = 1'b0;
            end
            if (door_open === 1'b1) begin
                dlen++;
            end else if (prev_door) begin
                compared++;
                if (dlen != DWELL_CYCLES) begin
                    mismatched++;
                    $display("FAIL dwell_len: door open %0d cycles, required %0d", dlen, DWELL_CYCLES);
                end
                dlen = 0;
            end
            compared++;
            if (pending !== want) begin
                mismatched++;
                $display("FAIL pending_map: got %b, required %b", pending, want);
            end
            prev_door = door_open;
            st_valid = call_valid; st_floor = call_floor; st_door = door_open; st_cf = current_floor;
        end
    end

    // One clock of the car: travels one floor every TRAVEL cycles toward req_floor while scheduled.
    task automatic tick();
        @(posedge clk);
        #1;
        if (busy && !door_open && current_floor != req_floor) begin
            if (!moving) begin
                moving = 1'b1;
                tcnt = 0;
            end else begin
                tcnt++;
                if (tcnt >= TRAVEL) begin
                    tcnt = 0;
                    if (req_floor > current_floor) current_floor = current_floor + 3'd1;
                    else current_floor = current_floor - 3'd1;
                    if (current_floor == req_floor) moving = 1'b0;
                end
            end
        end else begin
            moving = 1'b0;
        end
    endtask

    task automatic issue_call(input logic [2:0] f);
        call_valid = 1'b1;
        call_floor = f;
        tick();
        call_valid = 1'b0;
    endtask

    task automatic place_car(input logic [2:0] f);
        current_floor = f;
        moving = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_door(input int max, output logic ok, output logic [2:0] fl);
        ok = 1'b0;
        fl = 3'd0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (door_open) begin
                ok = 1'b1;
                fl = current_floor;
                break;
            end
        end
    endtask

    task automatic wait_close(input int max, output int n);
        n = 1;
        for (int i = 0; i < max; i++) begin
            tick();
            if (!door_open) break;
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; call_valid = 1'b0; call_floor = 3'd0; current_floor = 3'd0; moving = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (req_floor !== 3'd0 || pending !== 8'd0 || dir_up !== 1'b1 || door_open !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_values: req=%0d pending=%b dir_up=%0b door=%0b busy=%0b, required 0/0/1/0/0",
                     req_floor, pending, dir_up, door_open, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_call();
        logic ok; logic [2:0] fl; int n;
        issue_call(3'd5);
        compared++;
        if (pending !== 8'h20) begin
            mismatched++; $display("FAIL first_call: pending %b, required %b", pending, 8'h20);
        end
        tick();
        compared++;
        if (busy !== 1'b1 || dir_up !== 1'b1) begin
            mismatched++; $display("FAIL start_up: busy=%0b dir_up=%0b, required 1/1", busy, dir_up);
        end
        tick();
        compared++;
        if (req_floor !== 3'd5) begin
            mismatched++; $display("FAIL target_5: req_floor %0d, required 5", req_floor);
        end
        wait_door(200, ok, fl);
        compared++;
        if (ok !== 1'b1 || fl !== 3'd5 || pending[5] !== 1'b0) begin
            mismatched++; $display("FAIL arrive_5: opened=%0b floor=%0d pending=%b, required 1/5/bit5 clear", ok, fl, pending);
        end
        wait_close(50, n);
        compared++;
        if (n != DWELL_CYCLES || busy !== 1'b0) begin
            mismatched++; $display("FAIL dwell_then_idle: open %0d cycles busy=%0b, required %0d/0", n, busy, DWELL_CYCLES);
        end
    endtask

    task automatic test_retarget();
        logic ok; logic [2:0] fl; int n; logic seen;
        place_car(3'd1);
        issue_call(3'd6);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (current_floor == 3'd2 && moving) begin seen = 1'b1; break; end
        end
        issue_call(3'd3);
        compared++;
        if (seen !== 1'b1 || req_floor !== 3'd3) begin
            mismatched++; $display("FAIL retarget_3: reached2=%0b req_floor %0d, required 1/3", seen, req_floor);
        end
        wait_door(200, ok, fl);
        compared++;
        if (ok !== 1'b1 || fl !== 3'd3) begin
            mismatched++; $display("FAIL stop_3: opened=%0b floor=%0d, required 1/3", ok, fl);
        end
        wait_close(50, n);
        wait_door(200, ok, fl);
        compared++;
        if (ok !== 1'b1 || fl !== 3'd6) begin
            mismatched++; $display("FAIL resume_6: opened=%0b floor=%0d, required 1/6", ok, fl);
        end
        wait_close(50, n);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL idle_after_6: busy %0b, required 0", busy);
        end
    endtask

    task automatic test_reversal();
        logic ok; logic [2:0] fl; int n; logic rev;
        place_car(3'd4);
        issue_call(3'd4);
        wait_door(50, ok, fl);
        issue_call(3'd2);
        issue_call(3'd1);
        wait_close(50, n);
        rev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dir_up === 1'b0 && busy === 1'b1) begin rev = 1'b1; break; end
        end
        compared++;
        if (rev !== 1'b1) begin
            mismatched++; $display("FAIL reverse_down: dir_up %0b busy %0b, required 0/1", dir_up, busy);
        end
        wait_door(200, ok, fl);
        compared++;
        if (ok !== 1'b1 || fl !== 3'd2) begin
            mismatched++; $display("FAIL down_first_2: opened=%0b floor=%0d, required 1/2", ok, fl);
        end
        wait_close(50, n);
        wait_door(200, ok, fl);
        compared++;
        if (ok !== 1'b1 || fl !== 3'd1 || dir_up !== 1'b0) begin
            mismatched++; $display("FAIL down_then_1: opened=%0b floor=%0d dir_up=%0b, required 1/1/0", ok, fl, dir_up);
        end
        wait_close(50, n);
    endtask

    task automatic test_arrival_collision();
        int n; logic there;
        issue_call(3'd3);
        there = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (current_floor == 3'd3 && !moving && !door_open) begin there = 1'b1; break; end
        end
        issue_call(3'd3);
        compared++;
        if (there !== 1'b1 || door_open !== 1'b1 || pending[3] !== 1'b0) begin
            mismatched++; $display("FAIL clear_wins: reached=%0b door=%0b pending=%b, required 1/1/bit3 clear", there, door_open, pending);
        end
        wait_close(50, n);
        compared++;
        if (n != DWELL_CYCLES || pending !== 8'd0 || busy !== 1'b0) begin
            mismatched++; $display("FAIL collision_dwell: open %0d pending=%b busy=%0b, required %0d/0/0", n, pending, busy, DWELL_CYCLES);
        end
    endtask

    task automatic test_reset_mid_dwell();
        logic ok; logic [2:0] fl; int bad;
        issue_call(3'd3);
        wait_door(50, ok, fl);
        issue_call(3'd2);
        issue_call(3'd7);
        #3;
        reset = 1'b1;
        #1;
        compared++;
        if (req_floor !== 3'd0 || pending !== 8'd0 || dir_up !== 1'b1 || door_open !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: req=%0d pending=%b dir_up=%0b door=%0b busy=%0b, required 0/0/1/0/0",
                     req_floor, pending, dir_up, door_open, busy);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy !== 1'b0 || pending !== 8'd0 || door_open !== 1'b0) bad++;
        end
        compared++;
        if (bad != 0 || req_floor !== current_floor) begin
            mismatched++; $display("FAIL no_stale_target: %0d busy cycles, req_floor %0d, required 0/%0d", bad, req_floor, current_floor);
        end
    endtask

    task automatic test_random();
        logic done;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 2) == 0) issue_call(3'($urandom_range(0, NUM_FLOORS - 1)));
            else tick();
        end
        done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (!busy && pending == 8'd0) begin done = 1'b1; break; end
        end
        compared++;
        if (done !== 1'b1 || want !== 8'd0) begin
            mismatched++; $display("FAIL random_drain: drained=%0b unserved calls %b, required 1/0", done, want);
        end
    endtask

`ifdef ELEV_SCHED_RECALL_EN
    task automatic test_recall();
        int opened; logic home;
        place_car(3'd6);
        issue_call(3'd7);
        tick();
        tick();
        recall = 1'b1;
        tick();
        compared++;
        if (pending !== 8'd0 || req_floor !== 3'd0 || dir_up !== 1'b0 || door_open !== 1'b0) begin
            mismatched++; $display("FAIL recall_force: pending=%b req=%0d dir_up=%0b door=%0b, required 0/0/0/0", pending, req_floor, dir_up, door_open);
        end
        opened = 0; home = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (door_open) opened++;
            if (current_floor == 3'd0 && !moving) begin home = 1'b1; break; end
        end
        tick();
        compared++;
        if (home !== 1'b1 || opened != 0 || busy !== 1'b0) begin
            mismatched++; $display("FAIL recall_home: home=%0b door_cycles=%0d busy=%0b, required 1/0/0", home, opened, busy);
        end
        recall = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_call();
        test_retarget();
        test_reversal();
        test_arrival_collision();
        test_reset_mid_dwell();
        test_random();
`ifdef ELEV_SCHED_RECALL_EN
        test_recall();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
